ofdm_frame_sequencer: RTL and testbench

Control block for the OFDM receive framer. It detects start of frame from the framer's sof, accepts the decoded SIGNAL header (length in bytes, data bits per symbol) and computes the payload symbol count with a sequential ceiling divider. It drives the framer's num_symbols/num_symbols_valid and tracks frame completion. A watchdog and error classification abort any frame that cannot complete, and the block reports status counters to the register file.

---
 rtl/ofdm_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ofdm_frame_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_sequencer.sv
// OFDM receive framer control: SOF detect, header intake, symbol-count
// divider, frame completion tracking, watchdog and status counters.
module ofdm_frame_sequencer #(
  parameter int MAX_NUM_SYMBOLS   = 256,
  parameter int LEN_W             = 12,
  parameter int DBPS_W            = 9,
  parameter int SERVICE_TAIL_BITS = 22,
  parameter int TIMEOUT_CYCLES    = 65535,
  localparam int NS_W = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              framer_sof,
  input  logic              framer_eof,
  input  logic              framer_last_beat,
  input  logic [LEN_W-1:0]  hdr_len,
  input  logic [DBPS_W-1:0] hdr_dbps,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  output logic [NS_W-1:0]   num_symbols,
  output logic              num_symbols_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error,
  output logic [2:0]        error_code,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       error_cnt
);

  localparam int REM_W = LEN_W + 4;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] E_BAD_HDR  = 3'd1;
  localparam logic [2:0] E_LATE_HDR = 3'd2;
  localparam logic [2:0] E_TIMEOUT  = 3'd3;
  localparam logic [2:0] E_OVERLAP  = 3'd4;
  localparam logic [2:0] E_OVERFLOW = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HDR,
    S_DIVIDE,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sof_d;
  logic [WD_W-1:0]     r_wd;
  logic [WD_W-1:0]     w_wd_nxt;
  logic [REM_W-1:0]    r_rem;
  logic [REM_W-1:0]    w_rem_nxt;
  logic [NS_W-1:0]     r_q;
  logic [NS_W-1:0]     w_q_nxt;
  logic [DBPS_W-1:0]   r_dbps;
  logic [DBPS_W-1:0]   w_dbps_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic [2:0]          w_code_nxt;

  logic                r_hdr_ready;
  logic [NS_W-1:0]     r_nsym;
  logic                r_nsym_vld;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [2:0]          r_code;
  logic [31:0]         r_fcnt;
  logic [15:0]         r_ecnt;

  logic w_start;
  logic w_end;
  logic w_timeout;
  logic w_active;

  assign w_start   = framer_sof & ~r_sof_d;
  assign w_end     = framer_eof & framer_last_beat;
  assign w_active  = (r_state != S_IDLE);
  assign w_timeout = w_active &&
                     (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = w_active ? r_wd + 1'b1 : r_wd;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_dbps_nxt  = r_dbps;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_code;
    if (w_start) begin
      w_wd_nxt    = '0;
      w_state_nxt = S_WAIT_HDR;
      if (w_active) begin
        w_err_nxt  = 1'b1;
        w_code_nxt = E_OVERLAP;
      end
    end else if (w_timeout) begin
      w_err_nxt   = 1'b1;
      w_code_nxt  = E_TIMEOUT;
      w_state_nxt = S_IDLE;
    end else if (w_end && (r_state == S_WAIT_HDR ||
                           r_state == S_DIVIDE)) begin
      w_err_nxt   = 1'b1;
      w_code_nxt  = E_LATE_HDR;
      w_state_nxt = S_IDLE;
    end else if (w_end && r_state == S_RUN) begin
      w_done_nxt  = 1'b1;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_WAIT_HDR: begin
          if (hdr_valid) begin
            if (hdr_len == '0 || hdr_dbps == '0) begin
              w_err_nxt   = 1'b1;
              w_code_nxt  = E_BAD_HDR;
              w_state_nxt = S_IDLE;
            end else begin
              w_rem_nxt   = (REM_W'(hdr_len) << 3) +
                            REM_W'(SERVICE_TAIL_BITS);
              w_q_nxt     = '0;
              w_dbps_nxt  = hdr_dbps;
              w_state_nxt = S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          if (r_rem <= REM_W'(r_dbps)) begin
            w_q_nxt     = r_q + 1'b1;
            w_state_nxt = S_RUN;
          end else if (r_q == NS_W'(MAX_NUM_SYMBOLS - 1)) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = E_OVERFLOW;
            w_state_nxt = S_IDLE;
          end else begin
            w_rem_nxt = r_rem - REM_W'(r_dbps);
            w_q_nxt   = r_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sof_d     <= 1'b0;
      r_wd        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dbps      <= '0;
      r_hdr_ready <= 1'b0;
      r_nsym      <= '0;
      r_nsym_vld  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= '0;
      r_fcnt      <= '0;
      r_ecnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sof_d     <= framer_sof;
      r_wd        <= w_wd_nxt;
      r_rem       <= w_rem_nxt;
      r_q         <= w_q_nxt;
      r_dbps      <= w_dbps_nxt;
      r_hdr_ready <= (w_state_nxt == S_WAIT_HDR);
      r_nsym_vld  <= (w_state_nxt == S_RUN);
      r_nsym      <= (w_state_nxt == S_RUN) ? w_q_nxt : '0;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_code      <= w_code_nxt;
      if (w_done_nxt)
        r_fcnt <= r_fcnt + 1'b1;
      if (w_err_nxt && r_ecnt != 16'hFFFF)
        r_ecnt <= r_ecnt + 1'b1;
    end
  end

  assign hdr_ready         = r_hdr_ready;
  assign num_symbols       = r_nsym;
  assign num_symbols_valid = r_nsym_vld;
  assign busy              = r_busy;
  assign frame_done        = r_done;
  assign frame_error       = r_err;
  assign error_code        = r_code;
  assign frame_cnt         = r_fcnt;
  assign error_cnt         = r_ecnt;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Directed bench for ofdm_frame_sequencer: header table plus
// timeout, late header, overlap, reset and saturation sequences.
module tb_ofdm_frame_sequencer;

  localparam int TMO = 600;

  logic        clk = 1'b0;
  logic        reset;
  logic        framer_sof;
  logic        framer_eof;
  logic        framer_last_beat;
  logic [11:0] hdr_len;
  logic [8:0]  hdr_dbps;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [8:0]  num_symbols;
  logic        num_symbols_valid;
  logic        busy;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  error_code;
  logic [31:0] frame_cnt;
  logic [15:0] error_cnt;

  ofdm_frame_sequencer #(
    .MAX_NUM_SYMBOLS(256),
    .LEN_W(12),
    .DBPS_W(9),
    .SERVICE_TAIL_BITS(22),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .framer_sof(framer_sof),
    .framer_eof(framer_eof),
    .framer_last_beat(framer_last_beat),
    .hdr_len(hdr_len),
    .hdr_dbps(hdr_dbps),
    .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready),
    .num_symbols(num_symbols),
    .num_symbols_valid(num_symbols_valid),
    .busy(busy),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .error_code(error_code),
    .frame_cnt(frame_cnt),
    .error_cnt(error_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] len;
    logic [8:0]  dbps;
    int          nsym;
    logic [2:0]  code;
  } vec_t;

  vec_t        vecs[10];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] fcnt_exp = 0;
  logic [15:0] ecnt_exp = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic bump_err();
    if (ecnt_exp != 16'hFFFF) ecnt_exp++;
  endtask

  // Wait at negedges for valid or error, bounded
  task automatic wait_evt(output int cyc, output bit hit);
    cyc = 0;
    hit = 0;
    for (int i = 0; i < 700; i++) begin
      if (frame_error || num_symbols_valid) begin
        hit = 1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic sof_pulse();
    @(negedge clk) framer_sof = 1'b1;
    @(negedge clk) framer_sof = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] len,
                           input logic [8:0] dbps,
                           input int ns,
                           input logic [2:0] code);
    int cyc;
    bit hit;
    bit unstable;
    sof_pulse();
    chk("hdr_ready_wait", 32'(hdr_ready), 1);
    hdr_len   = len;
    hdr_dbps  = dbps;
    hdr_valid = 1'b1;
    @(negedge clk) hdr_valid = 1'b0;
    wait_evt(cyc, hit);
    chk("event_seen", 32'(hit), 1);
    if (code != 0) begin
      bump_err();
      chk("err_pulse", 32'(frame_error), 1);
      chk("err_code", 32'(error_code), 32'(code));
      chk("err_nsym_vld", 32'(num_symbols_valid), 0);
      chk("err_cnt", 32'(error_cnt), 32'(ecnt_exp));
      @(negedge clk);
      chk("err_pulse_end", 32'(frame_error), 0);
    end else begin
      chk("nsym_vld", 32'(num_symbols_valid), 1);
      chk("nsym", 32'(num_symbols), 32'(ns));
      chk("div_cycles", 32'(cyc), 32'(ns));
      unstable = 0;
      for (int i = 0; i < ns; i++) begin
        framer_last_beat = 1'b1;
        framer_eof       = (i == ns - 1);
        @(negedge clk);
        if (i < ns - 1 &&
            (!num_symbols_valid || num_symbols != 9'(ns)))
          unstable = 1;
      end
      framer_last_beat = 1'b0;
      framer_eof       = 1'b0;
      fcnt_exp++;
      chk("nsym_stable", 32'(unstable), 0);
      chk("done_pulse", 32'(frame_done), 1);
      chk("vld_drop", 32'(num_symbols_valid), 0);
      chk("frame_cnt", frame_cnt, fcnt_exp);
      @(negedge clk);
      chk("done_pulse_end", 32'(frame_done), 0);
    end
  endtask

  initial begin
    int n;
    int cyc;
    bit hit;
    vecs[0] = '{12'd100,  9'd24,  35,  3'd0};
    vecs[1] = '{12'd5,    9'd62,  1,   3'd0};
    vecs[2] = '{12'd1,    9'd30,  1,   3'd0};
    vecs[3] = '{12'd31,   9'd256, 2,   3'd0};
    vecs[4] = '{12'd4095, 9'd511, 65,  3'd0};
    vecs[5] = '{12'd764,  9'd24,  256, 3'd0};
    vecs[6] = '{12'd0,    9'd24,  0,   3'd1};
    vecs[7] = '{12'd4,    9'd0,   0,   3'd1};
    vecs[8] = '{12'd766,  9'd24,  0,   3'd5};
    vecs[9] = '{12'd4095, 9'd24,  0,   3'd5};

    reset            = 1'b1;
    framer_sof       = 1'b0;
    framer_eof       = 1'b0;
    framer_last_beat = 1'b0;
    hdr_len          = '0;
    hdr_dbps         = '0;
    hdr_valid        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({hdr_ready, num_symbols, num_symbols_valid,
                         busy, frame_done, frame_error,
                         error_code}), 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ecnt", 32'(error_cnt), 0);
    reset = 1'b0;

    // header offered while idle must not be consumed
    hdr_len   = 12'd5;
    hdr_dbps  = 9'd62;
    hdr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hdr_ready", 32'(hdr_ready), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_no_err", 32'(frame_error), 0);
    hdr_valid = 1'b0;

    for (int v = 0; v < 10; v++)
      run_frame(vecs[v].len, vecs[v].dbps,
                vecs[v].nsym, vecs[v].code);

    // watchdog: sof with no header
    @(negedge clk) framer_sof = 1'b1;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 framer_sof = 1'b0;
      n++;
      if (frame_error) break;
    end
    bump_err();
    chk("timeout_cycles", 32'(n), TMO);
    chk("timeout_code", 32'(error_code), 3);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_ecnt", 32'(error_cnt), 32'(ecnt_exp));

    // frame end while header still pending
    sof_pulse();
    framer_eof       = 1'b1;
    framer_last_beat = 1'b1;
    @(negedge clk);
    framer_eof       = 1'b0;
    framer_last_beat = 1'b0;
    bump_err();
    chk("late_pulse", 32'(frame_error), 1);
    chk("late_code", 32'(error_code), 2);
    chk("late_busy", 32'(busy), 0);

    // new sof during RUN
    sof_pulse();
    hdr_len   = 12'd5;
    hdr_dbps  = 9'd62;
    hdr_valid = 1'b1;
    @(negedge clk) hdr_valid = 1'b0;
    wait_evt(cyc, hit);
    chk("ovl_run", 32'(num_symbols_valid), 1);
    sof_pulse();
    bump_err();
    chk("ovl_pulse", 32'(frame_error), 1);
    chk("ovl_code", 32'(error_code), 4);
    chk("ovl_vld", 32'(num_symbols_valid), 0);
    chk("ovl_hdr_ready", 32'(hdr_ready), 1);
    hdr_len   = 12'd100;
    hdr_dbps  = 9'd24;
    hdr_valid = 1'b1;
    @(negedge clk) hdr_valid = 1'b0;
    wait_evt(cyc, hit);
    chk("ovl_nsym", 32'(num_symbols), 35);
    framer_eof       = 1'b1;
    framer_last_beat = 1'b1;
    @(negedge clk);
    framer_eof       = 1'b0;
    framer_last_beat = 1'b0;
    fcnt_exp++;
    chk("ovl_done", 32'(frame_done), 1);
    chk("ovl_fcnt", frame_cnt, fcnt_exp);
    chk("ovl_ecnt", 32'(error_cnt), 32'(ecnt_exp));

    // reset in the middle of DIVIDE
    sof_pulse();
    hdr_len   = 12'd4095;
    hdr_dbps  = 9'd24;
    hdr_valid = 1'b1;
    @(negedge clk) hdr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_outs", 32'({hdr_ready, num_symbols,
                             num_symbols_valid, busy, frame_done,
                             frame_error, error_code}), 0);
    chk("mid_rst_fcnt", frame_cnt, 0);
    chk("mid_rst_ecnt", 32'(error_cnt), 0);
    @(negedge clk) reset = 1'b0;
    fcnt_exp = 0;

    // error counter saturation from a preloaded near-full value
    @(negedge clk);
    force dut.r_ecnt = 16'hFFFD;
    #1 release dut.r_ecnt;
    ecnt_exp = 16'hFFFD;
    for (int i = 0; i < 3; i++)
      run_frame(12'd0, 9'd24, 0, 3'd1);
    chk("sat_ecnt", 32'(error_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
